serial_nibble_rx: RTL and testbench

Serial-to-parallel receiver for the 4-bit universal shift-register transmitter path: it samples the serial stream the shifter emits (Q[3] when shifting right, Q[0] when shifting left) and rebuilds the original parallel word bit-for-bit in index order. Each completed word is presented on a holding register with a valid/ready handshake, plus overrun detection and frame resync. It sits on the receive side of the board-level shift link, beside the shift-register/mux/NAND glue top.

---
 rtl/serial_nibble_rx_pkg.sv | 15 +
 rtl/rx_hold_reg.sv | 69 ++++++
 rtl/serial_nibble_rx.sv | 101 ++++++++++
 tb/tb_serial_nibble_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_nibble_rx_pkg.sv
// Shared constants for the 4-bit shift link: direction codes, default word width and the
// receive holding-stage state encoding.
package serial_nibble_rx_pkg;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  localparam int unsigned W_DEFAULT = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/rx_hold_reg.sv
// Output holding stage for the serial receiver: one-word buffer with valid/ready handshake
// and a sticky overrun flag for words that arrive while the buffer is still unread.
module rx_hold_reg
  import serial_nibble_rx_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         complete_i,
  input  logic [0:W-1] word_i,
  input  logic         qrdy_i,
  input  logic         clr_i,
  output logic [0:W-1] q_o,
  output logic         qv_o,
  output logic         ovr_o
);

  hold_state_e  state_q, state_d;
  logic [0:W-1] q_q, q_d;
  logic         ovr_q, ovr_d;
  logic         overrun;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    overrun = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (complete_i) begin
          q_d     = word_i;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (complete_i) begin
          // A completion while the old word is being taken simply replaces it.
          if (qrdy_i) begin
            q_d = word_i;
          end else begin
            overrun = 1'b1;
          end
        end else if (qrdy_i) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Set beats clear when both happen on one edge.
    ovr_d = (ovr_q & ~clr_i) | overrun;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      q_q     <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      ovr_q   <= ovr_d;
    end
  end

  assign q_o   = q_q;
  assign qv_o  = (state_q == ST_FULL);
  assign ovr_o = ovr_q;

endmodule

// File: rtl/serial_nibble_rx.sv
// Serial-to-parallel receiver for the universal shift-register link: rebuilds the transmitter
// word in index order from a strobed bit stream, with frame resync and a handshaked output.
module serial_nibble_rx
  import serial_nibble_rx_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         CP,
  input  logic         MR,
  input  logic         SIN,
  input  logic         SEN,
  input  logic         DIR,
  input  logic         FS,
  input  logic         QRDY,
  input  logic         CLR,
  output logic [0:W-1] Q,
  output logic         QV,
  output logic         OVR,
  output logic         BUSY
);

  localparam int unsigned CW = $clog2(W);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CntLast = cnt_t'(W - 1);

  logic [0:W-1] sr_q, sr_d, sr_shift;
  cnt_t         cnt_q, cnt_d, cnt_base;
  logic         ldir_q, ldir_d;
  logic         busy_q, busy_d;
  logic         eff_dir;
  logic         complete;

  // FS discards the partial word, so a bit accepted on the same edge starts a new one.
  assign cnt_base = FS ? '0 : cnt_q;
  assign eff_dir  = (cnt_base == '0) ? DIR : ldir_q;

  always_comb begin
    sr_shift = sr_q;
    if (eff_dir == DIR_RIGHT) begin
      sr_shift[0] = SIN;
      for (int i = 1; i < int'(W); i++) begin
        sr_shift[i] = sr_q[i-1];
      end
    end else begin
      sr_shift[W-1] = SIN;
      for (int i = 0; i < int'(W) - 1; i++) begin
        sr_shift[i] = sr_q[i+1];
      end
    end
  end

  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_base;
    ldir_d   = ldir_q;
    complete = 1'b0;
    if (SEN) begin
      sr_d   = sr_shift;
      ldir_d = eff_dir;
      if (cnt_base == CntLast) begin
        cnt_d    = '0;
        complete = 1'b1;
      end else begin
        cnt_d = cnt_base + cnt_t'(1);
      end
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge CP) begin
    if (!MR) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      ldir_q <= DIR_RIGHT;
      busy_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      ldir_q <= ldir_d;
      busy_q <= busy_d;
    end
  end

  // The shifted view already holds the bit taken this edge, so it is the completed word.
  rx_hold_reg #(
    .W(W)
  ) u_hold (
    .clk_i     (CP),
    .rst_ni    (MR),
    .complete_i(complete),
    .word_i    (sr_shift),
    .qrdy_i    (QRDY),
    .clr_i     (CLR),
    .q_o       (Q),
    .qv_o      (QV),
    .ovr_o     (OVR)
  );

  assign BUSY = busy_q;

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Self-checking bench for serial_nibble_rx: directed link scenarios plus random traffic,
// compared each cycle against a word-level reference model.
module tb_serial_nibble_rx;
  import serial_nibble_rx_pkg::*;

  localparam int unsigned W = W_DEFAULT;

  logic         CP = 1'b0;
  logic         MR, SIN, SEN, DIR, FS, QRDY, CLR;
  logic [0:W-1] Q;
  logic         QV, OVR, BUSY;

  serial_nibble_rx #(
    .W(W)
  ) dut (
    .CP  (CP),
    .MR  (MR),
    .SIN (SIN),
    .SEN (SEN),
    .DIR (DIR),
    .FS  (FS),
    .QRDY(QRDY),
    .CLR (CLR),
    .Q   (Q),
    .QV  (QV),
    .OVR (OVR),
    .BUSY(BUSY)
  );

  always #5 CP = ~CP;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Reference model: bits of the word in progress, in arrival order.
  logic         m_bits[$];
  logic         m_dir;
  logic [0:W-1] m_q;
  logic         m_qv, m_ovr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [0:W-1] w;
    bit           done;
    bit           ovf;
    w    = '0;
    done = 1'b0;
    ovf  = 1'b0;
    if (!MR) begin
      m_bits.delete();
      m_dir = 1'b0;
      m_q   = '0;
      m_qv  = 1'b0;
      m_ovr = 1'b0;
      return;
    end
    if (FS) m_bits.delete();
    if (SEN) begin
      if (m_bits.size() == 0) m_dir = DIR;
      m_bits.push_back(SIN);
      if (m_bits.size() == int'(W)) begin
        // Right-shift source sends D[W-1] first; left-shift source sends D[0] first.
        for (int k = 0; k < int'(W); k++) begin
          if (m_dir == DIR_RIGHT) w[int'(W) - 1 - k] = m_bits[k];
          else                    w[k] = m_bits[k];
        end
        done = 1'b1;
        m_bits.delete();
      end
    end
    if (!m_qv) begin
      if (done) begin
        m_q  = w;
        m_qv = 1'b1;
      end
    end else if (done) begin
      if (QRDY) m_q = w;
      else      ovf = 1'b1;
    end else if (QRDY) begin
      m_qv = 1'b0;
    end
    m_ovr = (m_ovr && !CLR) || ovf;
  endtask

  task automatic tick();
    @(posedge CP);
    model_edge();
    chk_en = 1'b1;
    #1;
  endtask

  task automatic send(input logic b, input logic d);
    SEN = 1'b1;
    SIN = b;
    DIR = d;
    tick();
    SEN = 1'b0;
  endtask

  task automatic drain();
    QRDY = 1'b1;
    tick();
    QRDY = 1'b0;
  endtask

  always @(negedge CP) begin
    if (chk_en) begin
      chk("q", 32'(Q), 32'(m_q));
      chk("qv", 32'(QV), 32'(m_qv));
      chk("ovr", 32'(OVR), 32'(m_ovr));
      chk("busy", 32'(BUSY), 32'(m_bits.size() != 0));
    end
  end

  initial begin
    MR = 1'b0; SEN = 1'b1; SIN = 1'($urandom); DIR = 1'b0;
    FS = 1'b0; QRDY = 1'b0; CLR = 1'b0;
    tick();
    SIN = 1'($urandom);
    tick();
    chk("rst_q", 32'(Q), 32'h0);
    chk("rst_qv", 32'(QV), 32'h0);
    chk("rst_ovr", 32'(OVR), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    MR = 1'b1; SEN = 1'b0;
    tick();

    // Right-shift source, D[0:3]=1101.
    send(1'b1, DIR_RIGHT); chk("r_busy1", 32'(BUSY), 32'h1);
    send(1'b0, DIR_RIGHT); chk("r_busy2", 32'(BUSY), 32'h1);
    send(1'b1, DIR_RIGHT); chk("r_busy3", 32'(BUSY), 32'h1);
    chk("r_qv3", 32'(QV), 32'h0);
    send(1'b1, DIR_RIGHT);
    chk("r_q", 32'(Q), 32'hd);
    chk("r_qv", 32'(QV), 32'h1);
    chk("r_busy4", 32'(BUSY), 32'h0);
    drain();
    chk("r_drain_qv", 32'(QV), 32'h0);

    // Left-shift source, DIR toggled mid-word must be ignored.
    send(1'b1, DIR_LEFT);
    send(1'b1, DIR_LEFT);
    send(1'b0, DIR_RIGHT);
    send(1'b1, DIR_RIGHT);
    chk("l_q", 32'(Q), 32'hd);
    chk("l_qv", 32'(QV), 32'h1);
    drain();

    // Back-to-back words 0011 then 1000; second completes while the first is taken.
    send(1'b1, DIR_RIGHT); send(1'b1, DIR_RIGHT); send(1'b0, DIR_RIGHT); send(1'b0, DIR_RIGHT);
    chk("b1_q", 32'(Q), 32'h3);
    send(1'b0, DIR_RIGHT); send(1'b0, DIR_RIGHT); send(1'b0, DIR_RIGHT);
    chk("b_qv_mid", 32'(QV), 32'h1);
    QRDY = 1'b1;
    send(1'b1, DIR_RIGHT);
    QRDY = 1'b0;
    chk("b2_q", 32'(Q), 32'h8);
    chk("b2_qv", 32'(QV), 32'h1);
    chk("b2_ovr", 32'(OVR), 32'h0);
    drain();

    // Overrun: 0101 held, 1110 dropped.
    send(1'b1, DIR_RIGHT); send(1'b0, DIR_RIGHT); send(1'b1, DIR_RIGHT); send(1'b0, DIR_RIGHT);
    send(1'b0, DIR_RIGHT); send(1'b1, DIR_RIGHT); send(1'b1, DIR_RIGHT); send(1'b1, DIR_RIGHT);
    chk("o_q", 32'(Q), 32'h5);
    chk("o_ovr", 32'(OVR), 32'h1);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    chk("o_clr_ovr", 32'(OVR), 32'h0);
    chk("o_clr_qv", 32'(QV), 32'h1);
    drain();

    // FS resync: two stale bits, then a fresh 1101 starting on the FS edge.
    send(1'b0, DIR_RIGHT); send(1'b1, DIR_RIGHT);
    FS = 1'b1;
    send(1'b1, DIR_RIGHT);
    FS = 1'b0;
    chk("fs_busy1", 32'(BUSY), 32'h1);
    send(1'b0, DIR_RIGHT); chk("fs_busy2", 32'(BUSY), 32'h1);
    send(1'b1, DIR_RIGHT); chk("fs_busy3", 32'(BUSY), 32'h1);
    send(1'b1, DIR_RIGHT);
    chk("fs_busy4", 32'(BUSY), 32'h0);
    chk("fs_q", 32'(Q), 32'hd);
    chk("fs_qv", 32'(QV), 32'h1);

    // Reset mid-word.
    send(1'b1, DIR_RIGHT); send(1'b0, DIR_RIGHT);
    MR = 1'b0;
    tick();
    MR = 1'b1;
    chk("mr_q", 32'(Q), 32'h0);
    chk("mr_qv", 32'(QV), 32'h0);
    chk("mr_busy", 32'(BUSY), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      MR   = ($urandom_range(0, 199) != 0);
      SEN  = ($urandom_range(0, 3) != 0);
      SIN  = 1'($urandom);
      DIR  = 1'($urandom);
      FS   = ($urandom_range(0, 29) == 0);
      QRDY = ($urandom_range(0, 2) == 0);
      CLR  = ($urandom_range(0, 15) == 0);
      tick();
    end

    SEN = 1'b0; FS = 1'b0; QRDY = 1'b0; CLR = 1'b0; MR = 1'b1;
    @(negedge CP);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
